// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 keyboard deserialiser that strips E0/F0 prefixes and emits one event per key.
//   clk        system clock, rising edge
//   clrn       synchronous active-low reset
//   ps2_clk    raw PS/2 clock (asynchronous)
//   ps2_data   raw PS/2 data (asynchronous)
//   key_code   last decoded Set-2 scan code, held between strobes
//   key_valid  one-cycle strobe when key_code/key_break/key_ext update
//   key_break  1 = release event
//   key_ext    1 = E0-prefixed code
//   key_down   1 after a make, 0 after a break
//   frame_err  one-cycle strobe for a discarded frame (start/stop/parity/timeout)
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of the key already down.
module ps2_scan_receiver #(
   parameter int TIMEOUT_CYC = 50000,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_code,
   output logic       key_valid,
   output logic       key_break,
   output logic       key_ext,
   output logic       key_down,
   output logic       frame_err
);
   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
   state_t           state, state_n;
   logic [2:0]       cs, ds;
   logic [3:0]       bit_cnt;
   logic [10:0]      sr;
   logic [CNT_W-1:0] tcnt;
   logic             chk, fe, tout, ok, byte_ok, emit, is_brk, is_ext;
   logic [7:0]       b;
   assign fe   = ~cs[1] & cs[2];
   assign tout = (bit_cnt != 4'd0) && !fe && (tcnt == CNT_W'(TIMEOUT_CYC));
   // sr holds the frame LSB-first: [0]=start, [8:1]=data, [9]=parity, [10]=stop
   assign ok   = ~sr[0] & sr[10] & (^sr[9:1]);
   assign b    = sr[8:1];
   always_ff @(posedge clk) begin
      if (!clrn) begin
         cs        <= '1;
         ds        <= '1;
         bit_cnt   <= '0;
         sr        <= '0;
         tcnt      <= '0;
         chk       <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         cs        <= {cs[1:0], ps2_clk};
         ds        <= {ds[1:0], ps2_data};
         chk       <= fe && (bit_cnt == 4'd10);
         frame_err <= tout || (chk && !ok);
         if (fe) begin
            sr      <= {ds[1], sr[10:1]};
            bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
            tcnt    <= '0;
         end else if (tout) begin
            bit_cnt <= '0;
            tcnt    <= '0;
         end else begin
            tcnt    <= (bit_cnt == 4'd0) ? '0 : tcnt + CNT_W'(1);
         end
      end
   end
   always_comb begin
      state_n = state;
      emit    = 1'b0;
      byte_ok = chk && ok;
      is_brk  = (state == BRK) || (state == EXT_BRK);
      is_ext  = (state == EXT) || (state == EXT_BRK);
      if (byte_ok) begin
         if (b == 8'hE0) begin
            state_n = EXT;
         end else if (b == 8'hF0) begin
            state_n = is_ext ? EXT_BRK : BRK;
         end else begin
            state_n = IDLE;
`ifdef PS2_TYPEMATIC_FILTER_EN
            emit    = is_brk || !key_down || ({key_ext, key_code} != {is_ext, b});
`else
            emit    = 1'b1;
`endif
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!clrn) begin
         state     <= IDLE;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_break <= 1'b0;
         key_ext   <= 1'b0;
         key_down  <= 1'b0;
      end else begin
         state     <= state_n;
         key_valid <= emit;
         if (emit) begin
            key_code  <= b;
            key_break <= is_brk;
            key_ext   <= is_ext;
            key_down  <= !is_brk;
         end
      end
   end
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: scoreboard bench driving PS/2 frames and checking decoded events.
module tb_ps2_scan_receiver;
   localparam int TO   = 200;
   localparam int HALF = 8;
   typedef struct {
      bit         err;
      logic [7:0] code;
      bit         brk;
      bit         ext;
      bit         down;
   } ev_t;
   logic       clk = 1'b0, clrn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [7:0] key_code;
   logic       key_valid, key_break, key_ext, key_down, frame_err;
   ev_t        exp_q[$];
   int         n_chk = 0, n_err = 0, cyc = 0, stop_cyc = 0;
   ps2_scan_receiver #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
      .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_code(key_code), .key_valid(key_valid), .key_break(key_break),
      .key_ext(key_ext), .key_down(key_down), .frame_err(frame_err)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic send_bits(input logic [7:0] d, input bit bad_par, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         idle(HALF);
         ps2_clk = 1'b0;
         if (i == 10) stop_cyc = cyc;
         idle(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      idle(3 * HALF);
   endtask
   task automatic send(input logic [7:0] d);
      send_bits(d, 1'b0, 11);
   endtask
   task automatic expect_key(input logic [7:0] c, input bit brk, input bit ext);
      ev_t e;
      e.err = 1'b0; e.code = c; e.brk = brk; e.ext = ext; e.down = !brk;
      exp_q.push_back(e);
   endtask
   task automatic expect_err();
      ev_t e;
      e.err = 1'b1; e.code = '0; e.brk = 1'b0; e.ext = 1'b0; e.down = 1'b0;
      exp_q.push_back(e);
   endtask
   // Monitor: every strobe pops one expected event
   always @(negedge clk) begin
      if (clrn && (key_valid || frame_err)) begin
         ev_t e;
         check("valid_err_overlap", {31'd0, key_valid & frame_err}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", {30'd0, key_valid, frame_err}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("strobe_kind", {31'd0, frame_err}, {31'd0, e.err});
            if (!e.err) begin
               check("key_code", {24'd0, key_code}, {24'd0, e.code});
               check("key_break", {31'd0, key_break}, {31'd0, e.brk});
               check("key_ext", {31'd0, key_ext}, {31'd0, e.ext});
               check("key_down", {31'd0, key_down}, {31'd0, e.down});
               check("latency", cyc - stop_cyc, 32'd4);
            end
         end
      end
   end
   initial begin
      idle(4);
      check("rst_key_code", {24'd0, key_code}, 32'd0);
      check("rst_flags", {27'd0, key_valid, key_break, key_ext, key_down, frame_err}, 32'd0);
      clrn = 1'b1;
      idle(4);
      expect_key(8'h1C, 1'b0, 1'b0); send(8'h1C);
      expect_key(8'h1C, 1'b1, 1'b0); send(8'hF0); send(8'h1C);
      expect_key(8'h75, 1'b0, 1'b1); send(8'hE0); send(8'h75);
      expect_key(8'h75, 1'b1, 1'b1); send(8'hE0); send(8'hF0); send(8'h75);
      expect_err(); send_bits(8'h1C, 1'b1, 11);
      expect_key(8'h32, 1'b0, 1'b0); send(8'h32);
      expect_err(); send_bits(8'h5A, 1'b0, 5);
      idle(TO + 5);
      expect_key(8'h5A, 1'b0, 1'b0); send(8'h5A);
      expect_key(8'h1C, 1'b0, 1'b0); send(8'h1C);
`ifndef PS2_TYPEMATIC_FILTER_EN
      expect_key(8'h1C, 1'b0, 1'b0);
`endif
      send(8'h1C);
`ifndef PS2_TYPEMATIC_FILTER_EN
      expect_key(8'h1C, 1'b0, 1'b0);
`endif
      send(8'h1C);
      expect_key(8'h1C, 1'b1, 1'b0); send(8'hF0); send(8'h1C);
      send_bits(8'h99, 1'b0, 6);
      clrn = 1'b0;
      idle(3);
      check("midrst_key_code", {24'd0, key_code}, 32'd0);
      check("midrst_flags", {27'd0, key_valid, key_break, key_ext, key_down, frame_err}, 32'd0);
      clrn = 1'b1;
      idle(4);
      expect_key(8'h2B, 1'b0, 1'b0); send(8'h2B);
      idle(TO + 20);
      check("pending_events", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/ps2_scan_receiver.md
Name: ps2_scan_receiver

Overview:
- Upstream stage of the scan-code-to-ASCII mapper.
- Deserialises the PS/2 keyboard line (ps2_clk/ps2_data), checks each 11-bit frame, and strips the E0 (extended) and F0 (break) prefixes.
- Presents one clean Set-2 scan code per key event on key_code with a single-cycle key_valid strobe, plus make/break and extended flags.
- key_code is held stable between strobes, so the mapper can sample it on either clock edge.

Parameters:
- TIMEOUT_CYC, 50000, clk cycles without a ps2_clk falling edge mid-frame before the partial frame is abandoned (1 ms at 50 MHz).
- CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clrn  in  1  synchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock from pad, asynchronous.
- ps2_data  in  1  raw PS/2 data from pad, asynchronous.
- key_code  out  8  last decoded scan code, prefix bytes removed.
- key_valid  out  1  one-cycle strobe: key_code/key_break/key_ext updated this cycle.
- key_break  out  1  1 = release event (F0-prefixed).
- key_ext  out  1  1 = E0-prefixed code.
- key_down  out  1  level: 1 after a make event, 0 after a break event.
- frame_err  out  1  one-cycle strobe: frame discarded (start, stop, parity or timeout).

Behaviour:
- Reset (clrn=0 at a clk rising edge):
  - All outputs go to 0.
  - Bit counter, shift register, timeout counter and protocol FSM are cleared.
  - The synchroniser stages load 1 (PS/2 line idle).
  - A frame in progress is dropped silently, with no frame_err.
- Synchroniser: 3 flops each on ps2_clk and ps2_data.
  - Falling edge detect fe = (stage2==0 && stage3==1).
  - ps2_data stage2 is sampled when fe=1.
- Frame: start(0), D0..D7 LSB first, odd parity, stop(1). Bit counter runs 0..10 and advances on each fe.
- On the fe that samples bit 10, the counter returns to 0 and the frame is checked in the next cycle:
  - ok = start==0 && stop==1 && ^{D,parity}==1.
  - ok=0 -> frame_err=1 for one cycle; the byte is discarded and the FSM is unchanged.
- Timeout:
  - The counter increments every clk cycle while bit counter != 0 and clears on each fe.
  - On reaching TIMEOUT_CYC: bit counter goes to 0, frame_err pulses one cycle, and the FSM is unchanged.
  - The counter is held at 0 while bit counter == 0.
- Protocol FSM, states IDLE, EXT, BRK, EXT_BRK, applied to each accepted byte b:
  - b==E0: IDLE->EXT; EXT->EXT; BRK->EXT; EXT_BRK->EXT.
  - b==F0: IDLE->BRK; EXT->EXT_BRK; BRK->BRK; EXT_BRK->EXT_BRK.
  - Any other b: emit the event and go to IDLE.
    - key_code=b.
    - key_break=(state in BRK/EXT_BRK).
    - key_ext=(state in EXT/EXT_BRK).
    - key_valid=1 for one cycle.
    - key_down is set to !key_break.
- Latency: key_valid is asserted exactly 2 clk cycles after the cycle in which fe is high for the stop bit (1 cycle frame check, 1 cycle FSM/output register).
- key_code, key_break, key_ext and key_down hold their values until the next emitted event.
- A frame_err cycle never coincides with key_valid.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined: a make event is suppressed (no key_valid, outputs unchanged) when key_down==1 and {key_ext,key_code} equals the incoming make. Break events and makes of different codes are always emitted.
- Undefined: every typematic repeat make is emitted with its own key_valid strobe.

Test Plan:
- Frame 0x1C (parity 0, stop 1) -> after 2 cycles: key_valid pulse, key_code=1C, key_break=0, key_ext=0, key_down=1.
- Frames F0,1C -> single key_valid on the second byte only: key_code=1C, key_break=1, key_down=0.
- Frames E0,75 then E0,F0,75 -> two strobes:
  - first with key_ext=1, key_break=0;
  - second with key_ext=1, key_break=1;
  - key_code=75 both times.
- Frame 0x1C sent with parity bit 1 -> frame_err one-cycle pulse, no key_valid. Then a clean 0x32 -> key_code=32.
- 5 bits sent, line stalled TIMEOUT_CYC+5 cycles -> one frame_err pulse, bit counter 0. Then clean 0x5A -> key_code=5A with no error.
- Makes 1C,1C,1C then F0,1C -> 2 strobes with the macro defined, 4 strobes without. Separately: clrn=0 mid-frame at bit 6, then a clean frame decodes correctly with no frame_err.
